// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: memory-stage FSM states, fault codes and access-size codes.
package pipe_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } fsm_state_t;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam int WAIT_CNT_W = 4;

    // Size code 2'b11 has no legal access width, so it is never aligned.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SIZE_BYTE: is_aligned = 1'b1;
            SIZE_HALF: is_aligned = ~addr_lo[0];
            SIZE_WORD: is_aligned = (addr_lo == 2'b00);
            default:   is_aligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half out of the read word and sign- or zero-extends it.
module load_align
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            addr_lo,
    input  logic [2:0]            funct3,
    output logic [DATA_WIDTH-1:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic        ext_b;
    logic        ext_h;

    // Halves are only ever taken from aligned addresses, so addr_lo[0] is ignored there.
    assign lane_b = rdata[{addr_lo, 3'b000} +: 8];
    assign lane_h = rdata[{addr_lo[1], 4'b0000} +: 16];
    assign ext_b  = ~funct3[2] & lane_b[7];
    assign ext_h  = ~funct3[2] & lane_h[15];

    always_comb begin
        case (funct3[1:0])
            SIZE_BYTE: data = {{(DATA_WIDTH-8){ext_b}}, lane_b};
            SIZE_HALF: data = {{(DATA_WIDTH-16){ext_h}}, lane_h};
            default:   data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: data-bus handshake with wait/timeout handling and the M/W register.
module mem_stage
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] ALUResultM,
    input  logic [DATA_WIDTH-1:0] WriteDataM,
    input  logic [DATA_WIDTH-1:0] PCPlus4M,
    input  logic [4:0]            RdM,
    input  logic                  RegWriteM,
    input  logic                  MemWriteM,
    input  logic                  MemReadM,
    input  logic [1:0]            ResultSrcM,
    input  logic [2:0]            Funct3M,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [DATA_WIDTH-1:0] dmem_addr,
    output logic [3:0]            dmem_be,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    input  logic                  dmem_ack,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    output logic                  StallM,
    output logic [DATA_WIDTH-1:0] ReadDataW,
    output logic [DATA_WIDTH-1:0] ALUResultW,
    output logic [DATA_WIDTH-1:0] PCPlus4W,
    output logic [4:0]            RdW,
    output logic                  RegWriteW,
    output logic [1:0]            ResultSrcW,
    output logic [1:0]            FaultW
);

    localparam int LANES = DATA_WIDTH / 8;

    fsm_state_t             state_reg, state_next;
    logic [WAIT_CNT_W-1:0]  cnt_reg, cnt_next;
    logic [WAIT_CNT_W:0]    cnt_inc;

    logic                   access;
    logic                   is_read;
    logic                   misaligned;
    logic                   bus_access;
    logic                   timeout_hit;
    logic                   ack_done;
    logic [1:0]             size;
    logic [1:0]             addr_lo;
    logic [DATA_WIDTH-1:0]  load_data;

    assign size       = Funct3M[1:0];
    assign addr_lo    = ALUResultM[1:0];
    assign access     = MemReadM | MemWriteM;
    assign is_read    = MemReadM & ~MemWriteM;
    assign misaligned = access & ~is_aligned(size, addr_lo);
    assign bus_access = access & ~misaligned;
    assign cnt_inc    = {1'b0, cnt_reg} + (WAIT_CNT_W+1)'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = '0;
        case (state_reg)
            ST_IDLE: begin
                if (bus_access && !dmem_ack) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (dmem_ack || timeout_hit) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_inc[WAIT_CNT_W-1:0];
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // The request is masked by reset so the bus sees nothing while rst_n is low,
    // even if the E/M register still presents an access.
    always_comb begin
        dmem_req    = 1'b0;
        timeout_hit = 1'b0;
        case (state_reg)
            ST_IDLE: dmem_req = bus_access;
            ST_WAIT: begin
                dmem_req    = 1'b1;
                timeout_hit = !dmem_ack && (cnt_inc == (WAIT_CNT_W+1)'(TIMEOUT));
            end
            default: dmem_req = 1'b0;
        endcase
        if (!rst_n) begin
            dmem_req    = 1'b0;
            timeout_hit = 1'b0;
        end
        ack_done = dmem_req & dmem_ack;
        StallM   = dmem_req & ~dmem_ack & ~timeout_hit;
    end

    assign dmem_we   = dmem_req & MemWriteM;
    assign dmem_addr = {ALUResultM[DATA_WIDTH-1:2], 2'b00};

    always_comb begin
        case (size)
            SIZE_BYTE: dmem_be = 4'b0001 << addr_lo;
            SIZE_HALF: dmem_be = 4'b0011 << addr_lo;
            default:   dmem_be = 4'b1111;
        endcase
    end

    // Replicating the store byte/half into every lane leaves it wherever the enables point.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_wlane
        assign dmem_wdata[8*gi +: 8] =
            (size == SIZE_BYTE) ? WriteDataM[7:0] :
            (size == SIZE_HALF) ? WriteDataM[8*(gi%2) +: 8] :
                                  WriteDataM[8*gi +: 8];
    end

    load_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_load_align (
        .rdata   (dmem_rdata),
        .addr_lo (addr_lo),
        .funct3  (Funct3M),
        .data    (load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ReadDataW  <= '0;
            ALUResultW <= '0;
            PCPlus4W   <= '0;
            RdW        <= '0;
            RegWriteW  <= 1'b0;
            ResultSrcW <= '0;
            FaultW     <= FAULT_NONE;
        end else if (StallM) begin
            RegWriteW <= 1'b0;
            FaultW    <= FAULT_NONE;
        end else begin
            ALUResultW <= ALUResultM;
            PCPlus4W   <= PCPlus4M;
            RdW        <= RdM;
            ResultSrcW <= ResultSrcM;
            ReadDataW  <= (is_read && ack_done) ? load_data : '0;
            if (misaligned) begin
                FaultW    <= FAULT_MISALIGN;
                RegWriteW <= 1'b0;
            end else if (timeout_hit) begin
                FaultW    <= FAULT_TIMEOUT;
                RegWriteW <= 1'b0;
            end else begin
                FaultW    <= FAULT_NONE;
                RegWriteW <= RegWriteM;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage against a transaction-level reference model.
module tb_mem_stage;

    localparam int DW = 32;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]    RdM;
    logic          RegWriteM, MemWriteM, MemReadM;
    logic [1:0]    ResultSrcM;
    logic [2:0]    Funct3M;
    logic          dmem_req, dmem_we;
    logic [DW-1:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]    dmem_be;
    logic          dmem_ack;
    logic          StallM;
    logic [DW-1:0] ReadDataW, ALUResultW, PCPlus4W;
    logic [4:0]    RdW;
    logic          RegWriteW;
    logic [1:0]    ResultSrcW, FaultW;

    int checks   = 0;
    int failures = 0;
    int txn_id   = 0;

    always #5 clk = ~clk;

    mem_stage #(
        .DATA_WIDTH (DW),
        .TIMEOUT    (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .PCPlus4M   (PCPlus4M),
        .RdM        (RdM),
        .RegWriteM  (RegWriteM),
        .MemWriteM  (MemWriteM),
        .MemReadM   (MemReadM),
        .ResultSrcM (ResultSrcM),
        .Funct3M    (Funct3M),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_be    (dmem_be),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .StallM     (StallM),
        .ReadDataW  (ReadDataW),
        .ALUResultW (ALUResultW),
        .PCPlus4W   (PCPlus4W),
        .RdW        (RdW),
        .RegWriteW  (RegWriteW),
        .ResultSrcW (ResultSrcW),
        .FaultW     (FaultW)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Access width in bytes; 0 means an illegal size code.
    function automatic int ref_bytes(input logic [2:0] f3);
        case (f3[1:0])
            2'd0:    return 1;
            2'd1:    return 2;
            2'd2:    return 4;
            default: return 0;
        endcase
    endfunction

    function automatic bit ref_misaligned(input logic [2:0] f3, input logic [31:0] a);
        int n;
        n = ref_bytes(f3);
        if (n == 0) return 1'b1;
        return (a % n) != 0;
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
        int n;
        int mask;
        n    = ref_bytes(f3);
        mask = (1 << n) - 1;
        return 4'(mask << (a % 4));
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
        case (ref_bytes(f3))
            1:       return (wd & 32'hFF) * 32'h0101_0101;
            2:       return (wd & 32'hFFFF) * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
        int          n;
        logic [31:0] v;
        logic [31:0] span;
        n = ref_bytes(f3);
        if (n == 4) return rd;
        span = 32'd1 << (8 * n);
        v    = (rd >> (8 * (a % 4))) % span;
        if (!f3[2] && v >= span / 2) v = v - span;
        return v;
    endfunction

    // Drives one instruction from posedge+1 and follows it until it leaves the stage.
    task automatic do_txn(input string name, input bit rd_en, input bit wr_en,
                          input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rdat, input int lat);
        bit          acc, mis, bus, tout, rw;
        int          stalls;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [1:0]  rs;
        logic [1:0]  exp_fault;
        acc    = rd_en || wr_en;
        mis    = acc && ref_misaligned(f3, addr);
        bus    = acc && !mis;
        stalls = bus ? ((lat < TO) ? lat : TO) : 0;
        tout   = bus && (lat > TO);
        rw     = 1'($urandom_range(0, 1));
        pc     = $urandom;
        rd     = 5'($urandom);
        rs     = 2'($urandom);
        exp_fault = mis ? 2'b01 : (tout ? 2'b10 : 2'b00);

        ALUResultM = addr;
        WriteDataM = wd;
        PCPlus4M   = pc;
        RdM        = rd;
        RegWriteM  = rw;
        MemReadM   = rd_en;
        MemWriteM  = wr_en;
        ResultSrcM = rs;
        Funct3M    = f3;

        for (int c = 0; c <= stalls; c++) begin
            dmem_ack   = bus ? (c == lat) : 1'($urandom_range(0, 1));
            dmem_rdata = (bus && c == lat) ? rdat : $urandom;
            @(negedge clk);
            check_eq({name, ".req"}, 32'(dmem_req), 32'(bus));
            check_eq({name, ".stall"}, 32'(StallM), 32'(c < stalls));
            if (bus) begin
                check_eq({name, ".addr"}, dmem_addr, addr & 32'hFFFF_FFFC);
                check_eq({name, ".be"}, 32'(dmem_be), 32'(ref_be(f3, addr)));
                check_eq({name, ".we"}, 32'(dmem_we), 32'(wr_en));
                if (wr_en) check_eq({name, ".wdata"}, dmem_wdata, ref_wdata(f3, wd));
            end
            @(posedge clk);
            #1;
            if (c < stalls) begin
                check_eq({name, ".bubble_rw"}, 32'(RegWriteW), 32'd0);
                check_eq({name, ".bubble_fault"}, 32'(FaultW), 32'd0);
            end else begin
                check_eq({name, ".fault"}, 32'(FaultW), 32'(exp_fault));
                check_eq({name, ".regwrite"}, 32'(RegWriteW), 32'(rw && exp_fault == 2'b00));
                check_eq({name, ".alu"}, ALUResultW, addr);
                check_eq({name, ".pc4"}, PCPlus4W, pc);
                check_eq({name, ".rd"}, 32'(RdW), 32'(rd));
                check_eq({name, ".rsrc"}, 32'(ResultSrcW), 32'(rs));
                if (rd_en && !wr_en && exp_fault == 2'b00)
                    check_eq({name, ".rdata"}, ReadDataW, ref_load(f3, addr, rdat));
            end
        end
        dmem_ack = 1'b0;
        txn_id++;
        $display("txn %0d %s: rd=%0b wr=%0b f3=%0d addr=0x%08h lat=%0d stalls=%0d fault=%0d",
                 txn_id, name, rd_en, wr_en, f3, addr, lat, stalls, exp_fault);
    endtask

    task automatic drive_idle();
        ALUResultM = '0;
        WriteDataM = '0;
        PCPlus4M   = '0;
        RdM        = '0;
        RegWriteM  = 1'b0;
        MemReadM   = 1'b0;
        MemWriteM  = 1'b0;
        ResultSrcM = '0;
        Funct3M    = '0;
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b1;
        drive_idle();
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst.stall", 32'(StallM), 32'd0);
        check_eq("rst.req", 32'(dmem_req), 32'd0);
        check_eq("rst.regwrite", 32'(RegWriteW), 32'd0);
        check_eq("rst.fault", 32'(FaultW), 32'd0);
        check_eq("rst.rdata", ReadDataW, 32'd0);
        check_eq("rst.alu", ALUResultW, 32'd0);
        check_eq("rst.pc4", PCPlus4W, 32'd0);
        check_eq("rst.rd", 32'(RdW), 32'd0);
        check_eq("rst.rsrc", 32'(ResultSrcW), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_txn("sw_0wait",   1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 0);
        do_txn("lb_wait3",   1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_0000, 3);
        do_txn("lhu",        1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0, 32'hBEEF_1234, 0);
        do_txn("lw_misal",   1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0, 32'h0, 0);
        do_txn("lw_timeout", 1'b1, 1'b0, 3'b010, 32'h0000_0104, 32'h0, 32'h0, 100);
        do_txn("nop_ack",    1'b0, 1'b0, 3'b010, 32'h1234_5678, 32'h0, 32'h0, 0);
        do_txn("lw_lastack", 1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0, 32'hCAFE_F00D, TO);
        do_txn("rw_write",   1'b1, 1'b1, 3'b001, 32'h0000_0106, 32'h0000_A5C3, 32'h0, 1);
        do_txn("f3_11",      1'b0, 1'b1, 3'b011, 32'h0000_0300, 32'h0, 32'h0, 0);

        for (int i = 0; i < 150; i++) begin
            int          kind;
            int          lat;
            bit          r, w;
            logic [2:0]  f3;
            logic [31:0] a;
            kind = $urandom_range(0, 9);
            r    = (kind >= 2 && kind <= 6) || kind == 9;
            w    = (kind >= 7);
            f3   = 3'($urandom);
            a    = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (f3[1:0] == 2'b01) a[0] = 1'b0;
                if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
            end
            lat = ($urandom_range(0, 9) == 0) ? $urandom_range(TO - 2, TO + 3)
                                              : $urandom_range(0, 3);
            do_txn("rnd", r, w, f3, a, $urandom, $urandom, lat);
        end

        // Reset in the second WAIT cycle abandons the load.
        ALUResultM = 32'h0000_0200;
        PCPlus4M   = 32'h0000_1004;
        RdM        = 5'd7;
        RegWriteM  = 1'b1;
        MemReadM   = 1'b1;
        MemWriteM  = 1'b0;
        Funct3M    = 3'b010;
        dmem_ack   = 1'b0;
        @(negedge clk);
        check_eq("rstw.stall_pre", 32'(StallM), 32'd1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check_eq("rstw.stall_wait2", 32'(StallM), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rstw.stall", 32'(StallM), 32'd0);
        check_eq("rstw.req", 32'(dmem_req), 32'd0);
        check_eq("rstw.regwrite", 32'(RegWriteW), 32'd0);
        check_eq("rstw.fault", 32'(FaultW), 32'd0);
        check_eq("rstw.alu", ALUResultW, 32'd0);
        drive_idle();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rstw.no_wb", 32'(RegWriteW), 32'd0);
        do_txn("sb_after_rst", 1'b0, 1'b1, 3'b000, 32'h0000_0002, 32'h0000_0055, 32'h0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
